mux_arb_nxw: RTL and testbench
==============================

# mux_arb_nxw

Registered N-channel, W-bit selector for the datapath, generalising the fixed 4x32 combinational mux. Each channel offers a word with a request; the block selects one per cycle, either by explicit select (direct mode) or by round-robin arbitration, and holds it in a one-entry output register with a valid/ready handshake. Used where several producers (ALU result, memory data, immediates, forwarding paths) share one registered consumer port.

## Interface
- WIDTH, 32, data width per channel
- NCH, 4, number of channels (2..16; need not be a power of 2)
- SELW, $clog2(NCH), select/channel-index width (derived, not overridden)

- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- mode  in  1  0 = direct select via s, 1 = round-robin
- s  in  SELW  channel select, used in direct mode only
- a  in  NCH*WIDTH  channel data, flat; channel i at a[i*WIDTH +: WIDTH]
- req  in  NCH  per-channel request; channel i offers a[i] while req[i]=1
- gnt  out  NCH  one-hot acceptance, combinational, same cycle as capture
- y  out  WIDTH  registered selected word
- y_ch  out  SELW  index of channel that produced y
- y_valid  out  1  y holds an unconsumed word
- y_ready  in  1  consumer accepts y this cycle

## Operation
- Clock is clk; reset is asynchronous and active-low on clrn. Reset values: y=0, y_ch=0, y_valid=0, round-robin pointer ptr=0. gnt forced to 0 while clrn=0.
- load_en = !y_valid || y_ready. No grant when load_en=0 (backpressure).
- Direct mode (mode=0): if load_en and s<NCH and req[s]: gnt[s]=1, capture a[s] into y, s into y_ch. If s>=NCH or req[s]=0: no grant. ptr not modified.
- Round-robin (mode=1): winner = first i with req[i]=1 searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1. If load_en and any req: gnt[winner]=1, capture a[winner], y_ch=winner, ptr <= winner+1, wrapping NCH-1 -> 0 (wrap at NCH, not 2^SELW).
- Capture sets y_valid=1. If load_en and no grant, y_valid <= 0; y and y_ch hold last value.
- Simultaneous consume and capture (y_valid=1, y_ready=1, grant): new word replaces old in same edge, y_valid stays 1; full throughput, one word/cycle.
- While y_valid=1 and y_ready=0: y, y_ch, y_valid, ptr all stable; gnt=0.
- mode and s are sampled combinationally each cycle; a mode change affects the same cycle's selection, ptr retained across mode changes.
- gnt is at most one-hot; a producer treats gnt[i]=1 at a rising edge as word taken.
- Reset mid-operation discards the held word and clears ptr immediately.

## Timing
- Latency req/a -> y: 1 cycle (captured at the rising edge where gnt is asserted; y visible after that edge).
- gnt is a combinational function of req, mode, s, ptr, y_valid, y_ready, clrn; no combinational path from a to any output.
- y_valid falls the edge after the last word is consumed with no new grant.
- Round-robin fairness: with all NCH requesting and y_ready=1, each channel granted exactly once per NCH consecutive cycles.

## Test plan
- Direct sweep, NCH=4, WIDTH=32, y_ready=1, all req=1, a0=0000_0000, a1=0000_FFFF, a2=FFFF_0000, a3=FFFF_FFFF, s=0,1,2,3 on consecutive cycles -> y equals a[s] with y_ch=s one cycle later, gnt=0001,0010,0100,1000.
- Round-robin, all req=1, y_ready=1 from reset -> y_ch sequence 0,1,2,3,0,1; ptr wraps 3->0; y_valid continuously 1 after first edge.
- Backpressure: round-robin, req=1111, y_ready=0 for 3 cycles after first capture -> y, y_ch=0 stable, gnt=0000; on y_ready=1 -> next word from channel 1 captured the same edge, y_valid stays 1.
- Sparse req, round-robin: ptr=1, req=1001 -> grant channel 3, ptr->0; next req=1001 -> grant channel 0; req=0000 with y_ready=1 -> y_valid drops next edge, y holds.
- NCH=3: direct s=3 with req=111 -> no grant, y_valid 0; round-robin after granting channel 2 -> ptr=0, next grant channel 0.
- Reset mid-operation: y_valid=1, ptr=2, assert clrn=0 between edges -> y=0, y_ch=0, y_valid=0, gnt=0 immediately; after release, round-robin grants channel 0 first.

Source files
------------

// File: rtl/mux_arb_nxw.sv
// Registered N-channel, W-bit selector: direct-select or round-robin arbitration
// into a one-entry output register with a valid/ready handshake.
module mux_arb_nxw #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   mode,
    input  logic [SELW-1:0]        s,
    input  logic [NCH*WIDTH-1:0]   a,
    input  logic [NCH-1:0]         req,
    output logic [NCH-1:0]         gnt,
    output logic [WIDTH-1:0]       y,
    output logic [SELW-1:0]        y_ch,
    output logic                   y_valid,
    input  logic                   y_ready
);

    logic [WIDTH-1:0] r_y;
    logic [SELW-1:0]  r_y_ch;
    logic             r_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_en;
    logic             w_dir_hit;
    logic             w_rr_hit;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_hit;
    logic [SELW-1:0]  w_win;
    logic [SELW-1:0]  w_ptr_nxt;
    logic [NCH-1:0]   w_gnt;
    logic [WIDTH-1:0] w_sel_data;

    // clrn is folded in so gnt is low for the whole reset window, not just at edges
    assign w_load_en = clrn && (!r_valid || y_ready);

    // Compare against each legal index so an out-of-range s simply never matches
    always_comb begin
        w_dir_hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (s == SELW'(i) && req[i]) begin
                w_dir_hit = 1'b1;
            end
        end
    end

    // Search ptr, ptr+1, ... wrapping at NCH; first requester found wins
    always_comb begin : p_rr
        int unsigned pos;
        pos      = 0;
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            pos = 32'(r_ptr) + 32'(k);
            if (pos >= NCH) begin
                pos = pos - NCH;
            end
            if (!w_rr_hit && req[pos[SELW-1:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = pos[SELW-1:0];
            end
        end
    end

    assign w_hit     = mode ? w_rr_hit : w_dir_hit;
    assign w_win     = mode ? w_rr_idx : s;
    assign w_ptr_nxt = (w_win == SELW'(NCH - 1)) ? '0 : w_win + SELW'(1);

    always_comb begin
        w_gnt = '0;
        if (w_load_en && w_hit) begin
            for (int i = 0; i < NCH; i++) begin
                w_gnt[i] = (w_win == SELW'(i));
            end
        end
    end

    // AND-OR select keyed by the one-hot grant
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sel_data = w_sel_data | (a[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_y     <= '0;
            r_y_ch  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            if (w_hit) begin
                r_y     <= w_sel_data;
                r_y_ch  <= w_win;
                r_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign gnt     = w_gnt;
    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_valid;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!clrn) $onehot0(gnt));

    a_hold_stable : assert property (@(posedge clk) disable iff (!clrn)
        (y_valid && !y_ready) |=> (y_valid && $stable(y) && $stable(y_ch)));

    a_ptr_range : assert property (@(posedge clk) disable iff (!clrn)
        32'(r_ptr) < NCH);

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Directed bench for mux_arb_nxw: a 4-channel and a 3-channel instance on a shared clock/reset.
module tb_mux_arb_nxw;

    logic clk;
    logic clrn;

    // 4-channel instance
    logic         mode4;
    logic [1:0]   s4;
    logic [127:0] a4;
    logic [3:0]   req4;
    logic [3:0]   gnt4;
    logic [31:0]  y4;
    logic [1:0]   ych4;
    logic         yv4;
    logic         rdy4;

    // 3-channel instance
    logic         mode3;
    logic [1:0]   s3;
    logic [95:0]  a3;
    logic [2:0]   req3;
    logic [2:0]   gnt3;
    logic [31:0]  y3;
    logic [1:0]   ych3;
    logic         yv3;
    logic         rdy3;

    int n_cmp;
    int n_bad;

    logic [31:0] av4 [4];
    logic [31:0] av3 [3];

    mux_arb_nxw #(.WIDTH(32), .NCH(4)) u_dut4 (
        .clk     (clk),
        .clrn    (clrn),
        .mode    (mode4),
        .s       (s4),
        .a       (a4),
        .req     (req4),
        .gnt     (gnt4),
        .y       (y4),
        .y_ch    (ych4),
        .y_valid (yv4),
        .y_ready (rdy4)
    );

    mux_arb_nxw #(.WIDTH(32), .NCH(3)) u_dut3 (
        .clk     (clk),
        .clrn    (clrn),
        .mode    (mode3),
        .s       (s3),
        .a       (a3),
        .req     (req3),
        .gnt     (gnt3),
        .y       (y3),
        .y_ch    (ych3),
        .y_valid (yv3),
        .y_ready (rdy3)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input logic md, input logic [1:0] sel, input logic [3:0] rq,
                        input logic rdy);
        mode4 = md;
        s4    = sel;
        req4  = rq;
        rdy4  = rdy;
        #1;
    endtask

    task automatic set3(input logic md, input logic [1:0] sel, input logic [2:0] rq,
                        input logic rdy);
        mode3 = md;
        s3    = sel;
        req3  = rq;
        rdy3  = rdy;
        #1;
    endtask

    // gnt before the edge, then registered outputs after it
    task automatic cyc4(input string tag, input logic [3:0] eg, input logic ev,
                        input logic [1:0] ech, input logic [31:0] ey);
        check_val({tag, ".gnt"}, 32'(gnt4), 32'(eg));
        tick();
        check_val({tag, ".valid"}, 32'(yv4), 32'(ev));
        check_val({tag, ".ych"}, 32'(ych4), 32'(ech));
        check_val({tag, ".y"}, y4, ey);
    endtask

    task automatic cyc3(input string tag, input logic [2:0] eg, input logic ev,
                        input logic [1:0] ech, input logic [31:0] ey);
        check_val({tag, ".gnt"}, 32'(gnt3), 32'(eg));
        tick();
        check_val({tag, ".valid"}, 32'(yv3), 32'(ev));
        check_val({tag, ".ych"}, 32'(ych3), 32'(ech));
        check_val({tag, ".y"}, y3, ey);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        clk    = 1'b0;
        clrn   = 1'b0;
        av4[0] = 32'h0000_0000;
        av4[1] = 32'h0000_FFFF;
        av4[2] = 32'hFFFF_0000;
        av4[3] = 32'hFFFF_FFFF;
        av3[0] = 32'h1111_1111;
        av3[1] = 32'h2222_2222;
        av3[2] = 32'h3333_3333;
        a4     = {av4[3], av4[2], av4[1], av4[0]};
        a3     = {av3[2], av3[1], av3[0]};
        mode4  = 1'b1;
        s4     = 2'd0;
        req4   = 4'b1111;
        rdy4   = 1'b1;
        mode3  = 1'b0;
        s3     = 2'd0;
        req3   = 3'b000;
        rdy3   = 1'b1;

        // Reset state, with live requests that must not be granted
        #2;
        check_val("rst.gnt", 32'(gnt4), 32'h0);
        check_val("rst.valid", 32'(yv4), 32'h0);
        check_val("rst.ych", 32'(ych4), 32'h0);
        check_val("rst.y", y4, 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // Direct sweep s = 0..3
        for (int i = 0; i < 4; i++) begin
            set4(1'b0, 2'(i), 4'b1111, 1'b1);
            cyc4($sformatf("dir%0d", i), 4'(1 << i), 1'b1, 2'(i), av4[i]);
        end

        // Round-robin from ptr 0: 0,1,2,3,0,1
        for (int k = 0; k < 6; k++) begin
            set4(1'b1, 2'd0, 4'b1111, 1'b1);
            cyc4($sformatf("rr%0d", k), 4'(1 << (k % 4)), 1'b1, 2'(k % 4), av4[k % 4]);
        end

        // Reset mid-operation (valid=1, ptr=2): immediate clear
        #2;
        clrn = 1'b0;
        #1;
        check_val("midrst.gnt", 32'(gnt4), 32'h0);
        check_val("midrst.valid", 32'(yv4), 32'h0);
        check_val("midrst.ych", 32'(ych4), 32'h0);
        check_val("midrst.y", y4, 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // First grant after reset is channel 0, then backpressure for 3 cycles
        set4(1'b1, 2'd0, 4'b1111, 1'b1);
        cyc4("bp.first", 4'b0001, 1'b1, 2'd0, av4[0]);
        for (int k = 0; k < 3; k++) begin
            set4(1'b1, 2'd0, 4'b1111, 1'b0);
            cyc4($sformatf("bp.hold%0d", k), 4'b0000, 1'b1, 2'd0, av4[0]);
        end
        set4(1'b1, 2'd0, 4'b1111, 1'b1);
        cyc4("bp.release", 4'b0010, 1'b1, 2'd1, av4[1]);

        // Sparse requests: ptr 2 -> grant 0 (ptr 1) -> grant 3 (ptr 0) -> grant 0
        set4(1'b1, 2'd0, 4'b0001, 1'b1);
        cyc4("sp.to1", 4'b0001, 1'b1, 2'd0, av4[0]);
        set4(1'b1, 2'd0, 4'b1001, 1'b1);
        cyc4("sp.ch3", 4'b1000, 1'b1, 2'd3, av4[3]);
        set4(1'b1, 2'd0, 4'b1001, 1'b1);
        cyc4("sp.ch0", 4'b0001, 1'b1, 2'd0, av4[0]);
        set4(1'b1, 2'd0, 4'b0000, 1'b1);
        cyc4("sp.drain", 4'b0000, 1'b0, 2'd0, av4[0]);

        // Direct grant in between must leave ptr (1) alone
        set4(1'b0, 2'd3, 4'b1111, 1'b1);
        cyc4("mc.dir", 4'b1000, 1'b1, 2'd3, av4[3]);
        set4(1'b1, 2'd0, 4'b1111, 1'b1);
        cyc4("mc.rr", 4'b0010, 1'b1, 2'd1, av4[1]);

        // Direct select of a non-requesting channel: no grant, valid drops
        set4(1'b0, 2'd2, 4'b1011, 1'b1);
        cyc4("dir.noreq", 4'b0000, 1'b0, 2'd1, av4[1]);

        // Empty register loads even with y_ready low (ptr 2)
        set4(1'b1, 2'd0, 4'b0100, 1'b0);
        cyc4("empty.load", 4'b0100, 1'b1, 2'd2, av4[2]);

        // NCH=3: s=3 is out of range
        set3(1'b0, 2'd3, 3'b111, 1'b1);
        cyc3("n3.s3", 3'b000, 1'b0, 2'd0, 32'h0);
        set3(1'b0, 2'd2, 3'b111, 1'b1);
        cyc3("n3.dir2", 3'b100, 1'b1, 2'd2, av3[2]);
        // Round-robin grant of channel 2 wraps ptr to 0
        set3(1'b1, 2'd0, 3'b100, 1'b1);
        cyc3("n3.rr2", 3'b100, 1'b1, 2'd2, av3[2]);
        for (int k = 0; k < 4; k++) begin
            set3(1'b1, 2'd0, 3'b111, 1'b1);
            cyc3($sformatf("n3.rr%0d", k), 3'(1 << (k % 3)), 1'b1, 2'(k % 3), av3[k % 3]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
